seq_frame_tx: RTL and testbench
===============================

# seq_frame_tx

Serial frame transmitter. Accepts a parallel payload word on a valid/ready handshake and emits it on a one-bit line. Each frame is a fixed sync pattern (default 1011) followed by the payload, MSB first. The block is the sending end of the serial link whose receiving side runs the team's 1011 sequence detector, and it drives that detector's `in` input.

## Interface
- `SYNC_W`, default 4: sync pattern width in bits, 1..16.
- `SYNC`, default 4'b1011: sync pattern, transmitted MSB first.
- `DATA_W`, default 8: payload width in bits, 1..32.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `valid` input 1: `data_in` holds a payload to send.
- `data_in` input DATA_W: payload word; sampled only on accept.
- `ready` output 1: the block can accept a payload this cycle.
- `out` output 1: serial line, registered, driven 0 when idle.
- `busy` output 1: a frame is on the line.
- `last` output 1: `out` currently carries the final bit of the frame.

## Operation
- Accept occurs on a rising edge with `valid && ready`. On accept, `data_in` is captured into a shift register, so the caller may change it on the next cycle.
- State machine states: IDLE, SYNC, DATA, and PAR (PAR only when the macro in Configuration is defined).
- IDLE -> SYNC on accept.
- SYNC lasts SYNC_W cycles and puts `SYNC[SYNC_W-1]` down to `SYNC[0]` on `out`.
- SYNC -> DATA after the SYNC_W-th bit.
- DATA lasts DATA_W cycles and puts `data_in[DATA_W-1]` down to `data_in[0]` on `out`.
- DATA -> PAR when parity is enabled, otherwise DATA -> IDLE.
- PAR lasts 1 cycle.
- Bit counter is sized clog2(max(SYNC_W, DATA_W)). It loads to 0 at each state entry and is compared against width-1. It never wraps within a state.
- `ready` = (state == IDLE) || `last`. This allows back-to-back frames: an accept during the last-bit cycle goes straight to SYNC with no idle gap.
- In the last-bit cycle, an accept wins over the return to IDLE.
- `valid` without `ready` is ignored. No payload is queued and nothing is dropped silently, because the caller holds the payload until it is accepted.
- `busy` = (state != IDLE).
- `last` is high for exactly one cycle per frame: the final DATA bit, or the PAR bit when parity is enabled.
- `out` is 0 in IDLE, so the sync MSB of 1 is the first rising mark on the line.

## Timing
- Reset values: state = IDLE, `out` = 0, `ready` = 1, `busy` = 0, `last` = 0, shift register = 0, counter = 0.
- Latency: accept at edge N. The first sync bit appears on `out` after edge N and is valid during cycle N+1.
- Frame length is SYNC_W+DATA_W cycles, or +1 with parity. The default frame is 12 cycles, or 13 with parity.
- Sustained throughput with `valid` held high is one frame every SYNC_W+DATA_W(+1) cycles, with no gap cycles.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The frame is abandoned and not resumed. The first accept after reset release starts a fresh frame.
- `ready` and `busy` are combinational from registered state only. `ready` has no combinational path from `valid`.

## Configuration
- Macro: `SEQ_FRAME_TX_PARITY_EN`.
- Defined: the PAR state is compiled in. One bit follows the payload: the even-parity bit, equal to the XOR of all DATA_W payload bits. `last` marks the PAR bit.
- Not defined: no PAR state. The frame ends at `data_in[0]`, and `last` marks that bit.
- The sync pattern is never included in the parity.

## Test plan
- Reset: assert `rst` mid-cycle with no clock edge -> `out`=0, `ready`=1, `busy`=0, `last`=0 immediately; same values hold after release until the first accept.
- Single frame: `data_in`=8'hA5 accepted once -> `out` = 1,0,1,1, 1,0,1,0,0,1,0,1 over 12 cycles; `last` high on the 12th; `busy` high for cycles 1..12; then `out`=0 and `ready`=1. With the parity macro: a 13th bit of 0 follows.
- Back-to-back: `valid` held high with 8'hFF then 8'h00 -> 24 consecutive cycles 1011_11111111_1011_00000000 with no gap; parity variant 26 cycles with parity bits 0 and 0.
- Backpressure: assert `valid` with 8'h3C while a frame is on the line, changing `data_in` until accepted -> only the value present on the accepting edge (during the `last` cycle) is sent.
- Reset mid-frame: assert `rst` during the 6th bit -> `out`=0 at once. After release, accept 8'h81 -> a complete frame 1011_10000001 is sent.
- Loopback: drive `out` into the 1011 sequence detector, accept frames 8'h00 and 8'hB0 -> the detector flags each sync header, and flags the 1011 pattern embedded in the 8'hB0 payload.

Source files
------------

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter. A payload accepted on a valid/ready
// handshake is sent as a fixed sync pattern followed by the payload, both MSB
// first, on a registered one-bit line that idles low.
// Optional feature: define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit
// (XOR of the payload bits) after the payload.
module seq_frame_tx #(
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = SYNC_W'(4'b1011),
    parameter int                DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              last
);

    localparam int            MAX_W    = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int            CW       = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC_W - 1);
    localparam logic [CW-1:0] DATA_END = CW'(DATA_W - 1);
`ifndef SEQ_FRAME_TX_PARITY_EN
    localparam logic [CW-1:0] DATA_PRE = CW'((DATA_W >= 2) ? DATA_W - 2 : 0);
`endif

`ifdef SEQ_FRAME_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;
`endif

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [SYNC_W-1:0]   sync_q;
    logic                out_q;
    logic                last_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic                par_q;
`endif
    logic                accept;

    // Ready comes only from registered state, so a new frame can be taken
    // in the last-bit cycle without any path from valid.
    assign ready  = (state_q == S_IDLE) || last_q;
    assign busy   = (state_q != S_IDLE);
    assign accept = valid && ready;
    assign out    = out_q;
    assign last   = last_q;

    // Frame sequencer: one register update per line bit; an accept always
    // restarts the frame at the first sync bit, even in the last-bit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            sync_q  <= '0;
            out_q   <= 1'b0;
            last_q  <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (accept) begin
            state_q <= S_SYNC;
            cnt_q   <= '0;
            shift_q <= data_in;
            sync_q  <= SYNC << 1;
            out_q   <= SYNC[SYNC_W-1];
            last_q  <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q   <= ^data_in;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_q  <= 1'b0;
                    last_q <= 1'b0;
                end
                S_SYNC: begin
                    if (cnt_q == SYNC_END) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                        out_q   <= shift_q[DATA_W-1];
                        shift_q <= shift_q << 1;
`ifdef SEQ_FRAME_TX_PARITY_EN
                        last_q  <= 1'b0;
`else
                        last_q  <= (DATA_W == 1);
`endif
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                        out_q  <= sync_q[SYNC_W-1];
                        sync_q <= sync_q << 1;
                        last_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (cnt_q == DATA_END) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                        state_q <= S_PAR;
                        cnt_q   <= '0;
                        out_q   <= par_q;
                        last_q  <= 1'b1;
`else
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
                        last_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        out_q   <= shift_q[DATA_W-1];
                        shift_q <= shift_q << 1;
`ifdef SEQ_FRAME_TX_PARITY_EN
                        last_q  <= 1'b0;
`else
                        last_q  <= (cnt_q == DATA_PRE);
`endif
                    end
                end
`ifdef SEQ_FRAME_TX_PARITY_EN
                S_PAR: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    last_q  <= 1'b0;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Testbench for seq_frame_tx (default parameters). The expected line is
// modelled as a queue of pending bits: an accept appends a whole frame built
// from the sync pattern, the payload and optional parity; every clock edge
// consumes one bit.
module tb_seq_frame_tx;

    localparam int SYNC_W = 4;
    localparam int DATA_W = 8;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = SYNC_W + DATA_W + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data_in;
    logic       ready;
    logic       out;
    logic       busy;
    logic       last;

    int checks   = 0;
    int failures = 0;

    bit lineQ[$];

    // Free-running clock, period 10
    always #5 clk = ~clk;

    seq_frame_tx #(
        .SYNC_W (SYNC_W),
        .SYNC   (4'b1011),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .data_in (data_in),
        .ready   (ready),
        .out     (out),
        .busy    (busy),
        .last    (last)
    );

    function automatic logic [31:0] frameWord(input logic [7:0] d);
        logic [31:0] w;
        w = {20'd0, 4'b1011, d};
        if (PAR != 0) w = {w[30:0], ^d};
        return w;
    endfunction

    function automatic logic expOut();
        return (lineQ.size() != 0) ? lineQ[0] : 1'b0;
    endfunction

    function automatic logic expBusy();
        return lineQ.size() != 0;
    endfunction

    function automatic logic expLast();
        return lineQ.size() == 1;
    endfunction

    function automatic logic expReady();
        return lineQ.size() <= 1;
    endfunction

    task automatic pushFrame(input logic [7:0] d);
        logic [31:0] w;
        w = frameWord(d);
        for (int i = FL - 1; i >= 0; i--) lineQ.push_back(w[i]);
    endtask

    // Drive inputs for the coming edge, advance the model, move to next negedge
    task automatic advance(input logic v, input logic [7:0] d);
        logic acc;
        valid   = v;
        data_in = d;
        acc = v && expReady();
        if (lineQ.size() != 0) void'(lineQ.pop_front());
        if (acc) pushFrame(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; data_in = 8'h00;
        #2;
        checks++; if (out   !== 1'b0) begin failures++; $display("[TB] FAIL reset_out: got %b want 0", out); end
        checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b want 1", ready); end
        checks++; if (busy  !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (last  !== 1'b0) begin failures++; $display("[TB] FAIL reset_last: got %b want 0", last); end
        @(negedge clk);
        rst = 1'b0;
        lineQ.delete();
        for (int i = 0; i < 3; i++) begin
            checks++; if (out   !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_out: got %b want 0", out); end
            checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready: got %b want 1", ready); end
            checks++; if (busy  !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
            checks++; if (last  !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_last: got %b want 0", last); end
            advance(1'b0, 8'($urandom));
        end
    endtask

    task automatic test_single_frame();
        logic [12:0] expBits;
        expBits = (PAR != 0) ? 13'b1011101001010 : 13'b0101110100101;
        checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ready: got %b want 1", ready); end
        advance(1'b1, 8'hA5);
        for (int i = 0; i < FL; i++) begin
            checks++; if (out  !== expBits[FL-1-i]) begin failures++; $display("[TB] FAIL single_out bit %0d: got %b want %b", i, out, expBits[FL-1-i]); end
            checks++; if (last !== (i == FL - 1))   begin failures++; $display("[TB] FAIL single_last bit %0d: got %b want %b", i, last, (i == FL - 1)); end
            checks++; if (busy !== 1'b1)            begin failures++; $display("[TB] FAIL single_busy bit %0d: got %b want 1", i, busy); end
            advance(1'b0, 8'($urandom));
        end
        checks++; if (out   !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_out: got %b want 0", out); end
        checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL single_idle_ready: got %b want 1", ready); end
    endtask

    task automatic test_back_to_back();
        logic [25:0] b2b;
        b2b = (PAR != 0) ? 26'b1011_11111111_0_1011_00000000_0
                         : {2'b00, 24'b1011_11111111_1011_00000000};
        for (int c = 0; c <= 2 * FL; c++) begin
            if (c >= 1) begin
                checks++; if (out  !== b2b[2*FL-c]) begin failures++; $display("[TB] FAIL b2b_out cycle %0d: got %b want %b", c, out, b2b[2*FL-c]); end
                checks++; if (busy !== 1'b1)        begin failures++; $display("[TB] FAIL b2b_busy cycle %0d: got %b want 1", c, busy); end
                checks++; if (last !== expLast())   begin failures++; $display("[TB] FAIL b2b_last cycle %0d: got %b want %b", c, last, expLast()); end
            end
            advance(c < 2 * FL, (c == 0) ? 8'hFF : 8'h00);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c <= 2 * FL + 2; c++) begin
            checks++; if (out   !== expOut())   begin failures++; $display("[TB] FAIL bp_out cycle %0d: got %b want %b", c, out, expOut()); end
            checks++; if (last  !== expLast())  begin failures++; $display("[TB] FAIL bp_last cycle %0d: got %b want %b", c, last, expLast()); end
            checks++; if (ready !== expReady()) begin failures++; $display("[TB] FAIL bp_ready cycle %0d: got %b want %b", c, ready, expReady()); end
            checks++; if (busy  !== expBusy())  begin failures++; $display("[TB] FAIL bp_busy cycle %0d: got %b want %b", c, busy, expBusy()); end
            advance(c <= FL, (c == 0) ? 8'h3C : 8'($urandom));
        end
    endtask

    task automatic test_reset_midframe();
        logic [12:0] exp81;
        exp81 = (PAR != 0) ? 13'b1011100000010 : 13'b0101110000001;
        advance(1'b1, 8'($urandom));
        for (int i = 0; i < 5; i++) begin
            checks++; if (out !== expOut()) begin failures++; $display("[TB] FAIL rmf_pre_out bit %0d: got %b want %b", i, out, expOut()); end
            advance(1'b0, 8'h00);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (out   !== 1'b0) begin failures++; $display("[TB] FAIL rmf_out: got %b want 0", out); end
        checks++; if (ready !== 1'b1) begin failures++; $display("[TB] FAIL rmf_ready: got %b want 1", ready); end
        checks++; if (busy  !== 1'b0) begin failures++; $display("[TB] FAIL rmf_busy: got %b want 0", busy); end
        checks++; if (last  !== 1'b0) begin failures++; $display("[TB] FAIL rmf_last: got %b want 0", last); end
        lineQ.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out !== 1'b0) begin failures++; $display("[TB] FAIL rmf_release_out: got %b want 0", out); end
        advance(1'b1, 8'h81);
        for (int i = 0; i < FL; i++) begin
            checks++; if (out  !== exp81[FL-1-i]) begin failures++; $display("[TB] FAIL rmf_frame_out bit %0d: got %b want %b", i, out, exp81[FL-1-i]); end
            checks++; if (last !== expLast())     begin failures++; $display("[TB] FAIL rmf_frame_last bit %0d: got %b want %b", i, last, expLast()); end
            advance(1'b0, 8'($urandom));
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rmf_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_loopback();
        logic [3:0] hist;
        int hits;
        hist = 4'b0000;
        hits = 0;
        for (int c = 0; c <= 2 * FL + 3; c++) begin
            checks++; if (out !== expOut()) begin failures++; $display("[TB] FAIL loop_out cycle %0d: got %b want %b", c, out, expOut()); end
            hist = {hist[2:0], out};
            if (hist == 4'b1011) hits++;
            advance(c < 2 * FL, (c == 0) ? 8'h00 : 8'hB0);
        end
        checks++; if (hits !== 3) begin failures++; $display("[TB] FAIL loop_detect_count: got %0d want 3", hits); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300 + 2 * FL; c++) begin
            checks++; if (out   !== expOut())   begin failures++; $display("[TB] FAIL rand_out cycle %0d: got %b want %b", c, out, expOut()); end
            checks++; if (last  !== expLast())  begin failures++; $display("[TB] FAIL rand_last cycle %0d: got %b want %b", c, last, expLast()); end
            checks++; if (ready !== expReady()) begin failures++; $display("[TB] FAIL rand_ready cycle %0d: got %b want %b", c, ready, expReady()); end
            checks++; if (busy  !== expBusy())  begin failures++; $display("[TB] FAIL rand_busy cycle %0d: got %b want %b", c, busy, expBusy()); end
            advance((c < 300) && ($urandom_range(0, 3) != 0), 8'($urandom));
        end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_loopback();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
